// File: rtl/nios_dbg_pkg.sv
// Shared constants for the Nios debug command queue:
// virtual-JTAG IR codes and command field positions.
package nios_dbg_pkg;

  localparam int IR_OCIMEM    = 0;
  localparam int IR_BREAK     = 2;
  localparam int IR_TRACECTRL = 3;

  localparam int BIT_OCI_B   = 35;
  localparam int BIT_OCI_A   = 34;
  localparam int BIT_BRK_ACT = 37;
  localparam int BRK_IDX_HI  = 35;
  localparam int BRK_IDX_LO  = 34;
  localparam int BIT_TRC     = 15;

  // edges after reset before strobe edges are trusted
  localparam int SYNC_ARM = 3;

endpackage

// File: rtl/nios_dbg_cmd_fifo.sv
// Synchronous command FIFO; a push while full is accepted
// only when a pop frees a slot in the same cycle.
module nios_dbg_cmd_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_cnt == CW'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_data    = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/nios_system_nios_cpu_debug_cmd_queue.sv
// Debug slave command stage: syncs TCK update strobes into clk,
// queues captured commands and decodes one action per pop.
module nios_system_nios_cpu_debug_cmd_queue
  import nios_dbg_pkg::*;
#(
  parameter int DATA_W     = 38,
  parameter int IR_W       = 2,
  parameter int NUM_BRK    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [IR_W-1:0]    ir_in,
  input  logic [DATA_W-1:0]  sr,
  input  logic               vs_udr,
  input  logic               vs_uir,
  input  logic               cmd_ready,
  output logic [DATA_W-1:0]  jdo,
  output logic               take_action_ocimem_a,
  output logic               take_action_ocimem_b,
  output logic               take_no_action_ocimem_a,
  output logic [NUM_BRK-1:0] take_action_break,
  output logic [NUM_BRK-1:0] take_no_action_break,
  output logic               take_action_tracectrl,
  output logic               cmd_pending,
  output logic               cmd_overflow
);

  localparam int EW = IR_W + DATA_W;

  logic [1:0]         r_udr_s;
  logic [1:0]         r_uir_s;
  logic               r_udr_h;
  logic               r_uir_h;
  logic [1:0]         r_arm_cnt;
  logic               w_armed;
  logic               w_udr_p;
  logic               w_uir_p;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               w_drop;
  logic [EW-1:0]      w_q;
  logic [IR_W-1:0]    w_ir;
  logic [DATA_W-1:0]  w_d;
  logic [1:0]         w_k;
  logic               w_oci_a;
  logic               w_oci_b;
  logic               w_no_oci_a;
  logic               w_trc;
  logic [NUM_BRK-1:0] w_brk_act;
  logic [NUM_BRK-1:0] w_brk_no;

  // pulses are masked until history holds the post-reset level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_udr_s   <= '0;
      r_uir_s   <= '0;
      r_udr_h   <= 1'b0;
      r_uir_h   <= 1'b0;
      r_arm_cnt <= '0;
    end else begin
      r_udr_s <= {r_udr_s[0], vs_udr};
      r_uir_s <= {r_uir_s[0], vs_uir};
      r_udr_h <= r_udr_s[1];
      r_uir_h <= r_uir_s[1];
      if (!w_armed) r_arm_cnt <= r_arm_cnt + 1'b1;
    end
  end

  assign w_armed = (r_arm_cnt == 2'(SYNC_ARM));
  assign w_udr_p = w_armed & r_udr_s[1] & ~r_udr_h;
  assign w_uir_p = w_armed & r_uir_s[1] & ~r_uir_h;

  assign w_pop  = ~w_empty & cmd_ready;
  assign w_drop = w_udr_p & w_full & ~w_pop;

  nios_dbg_cmd_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_push  (w_udr_p),
    .i_pop   (w_pop),
    .i_data  ({ir_in, sr}),
    .o_data  (w_q),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_ir        = w_q[EW-1:DATA_W];
  assign w_d         = w_q[DATA_W-1:0];
  assign w_k         = w_d[BRK_IDX_HI:BRK_IDX_LO];
  assign cmd_pending = ~w_empty;

  always_comb begin
    w_oci_a    = 1'b0;
    w_oci_b    = 1'b0;
    w_no_oci_a = 1'b0;
    w_trc      = 1'b0;
    w_brk_act  = '0;
    w_brk_no   = '0;
    unique case (1'b1)
      (w_ir == IR_W'(IR_OCIMEM)): begin
        if (w_d[BIT_OCI_B])      w_oci_b    = 1'b1;
        else if (w_d[BIT_OCI_A]) w_oci_a    = 1'b1;
        else                     w_no_oci_a = 1'b1;
      end
      (w_ir == IR_W'(IR_BREAK)): begin
        for (int i = 0; i < NUM_BRK; i++) begin
          if (w_k == 2'(i)) begin
            w_brk_act[i] = w_d[BIT_BRK_ACT];
            w_brk_no[i]  = ~w_d[BIT_BRK_ACT];
          end
        end
      end
      (w_ir == IR_W'(IR_TRACECTRL)): w_trc = w_d[BIT_TRC];
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jdo                     <= '0;
      take_action_ocimem_a    <= 1'b0;
      take_action_ocimem_b    <= 1'b0;
      take_no_action_ocimem_a <= 1'b0;
      take_action_break       <= '0;
      take_no_action_break    <= '0;
      take_action_tracectrl   <= 1'b0;
      cmd_overflow            <= 1'b0;
    end else begin
      take_action_ocimem_a    <= w_pop & w_oci_a;
      take_action_ocimem_b    <= w_pop & w_oci_b;
      take_no_action_ocimem_a <= w_pop & w_no_oci_a;
      take_action_break       <= w_pop ? w_brk_act : '0;
      take_no_action_break    <= w_pop ? w_brk_no : '0;
      take_action_tracectrl   <= w_pop & w_trc;
      if (w_pop) jdo <= w_d;
      if (w_drop)       cmd_overflow <= 1'b1;
      else if (w_uir_p) cmd_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nios_system_nios_cpu_debug_cmd_queue.sv
// Scoreboard bench: expected commands queued at update time,
// checked against jdo and decoded strobes on each pop.
module tb_nios_system_nios_cpu_debug_cmd_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        vs_udr;
  logic        vs_uir;
  logic        cmd_ready;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic        take_no_action_ocimem_a;
  logic [2:0]  take_action_break;
  logic [2:0]  take_no_action_break;
  logic        take_action_tracectrl;
  logic        cmd_pending;
  logic        cmd_overflow;

  nios_system_nios_cpu_debug_cmd_queue dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .ir_in                   (ir_in),
    .sr                      (sr),
    .vs_udr                  (vs_udr),
    .vs_uir                  (vs_uir),
    .cmd_ready               (cmd_ready),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_break       (take_action_break),
    .take_no_action_break    (take_no_action_break),
    .take_action_tracectrl   (take_action_tracectrl),
    .cmd_pending             (cmd_pending),
    .cmd_overflow            (cmd_overflow)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [39:0] sb [$];
  logic [39:0] e;
  logic        pop_q = 1'b0;
  logic [9:0]  w_obs;

  assign w_obs = {take_action_ocimem_a, take_action_ocimem_b,
                  take_no_action_ocimem_a, take_action_tracectrl,
                  take_action_break, take_no_action_break};

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {oci_a, oci_b, no_oci_a, trc, act_brk[2:0], no_brk[2:0]}
  function automatic logic [9:0] exp_stb(input logic [1:0] ir,
                                         input logic [37:0] d);
    logic [9:0] v;
    v = '0;
    case (ir)
      2'd0: begin
        if (d[35])      v[8] = 1'b1;
        else if (d[34]) v[9] = 1'b1;
        else            v[7] = 1'b1;
      end
      2'd2: begin
        if (d[35:34] != 2'd3) begin
          if (d[37]) v[3 + int'(d[35:34])] = 1'b1;
          else       v[int'(d[35:34])]     = 1'b1;
        end
      end
      2'd3: v[6] = d[15];
      default: ;
    endcase
    return v;
  endfunction

  function automatic logic [37:0] mk(input logic act,
                                     input logic [1:0] k,
                                     input logic trc);
    logic [37:0] d;
    d[31:0]  = $urandom;
    d[37:32] = 6'($urandom);
    d[37]    = act;
    d[36]    = 1'b0;
    d[35:34] = k;
    d[15]    = trc;
    return d;
  endfunction

  always @(posedge clk) pop_q <= reset_n & cmd_pending & cmd_ready;

  always @(negedge clk) begin
    if (reset_n) begin
      if (pop_q) begin
        check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("jdo", 64'(jdo), 64'(e[37:0]));
          check("strobes", 64'(w_obs), 64'(exp_stb(e[39:38], e[37:0])));
        end
      end else begin
        check("idle_strobes", 64'(w_obs), 64'd0);
      end
    end
  end

  task automatic send(input logic [1:0] ir,
                      input logic [37:0] d,
                      input bit push);
    @(negedge clk);
    ir_in  = ir;
    sr     = d;
    vs_udr = 1'b1;
    if (push) sb.push_back({ir, d});
    repeat (5) @(negedge clk);
    vs_udr = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    ir_in     = '0;
    sr        = '0;
    vs_udr    = 1'b0;
    vs_uir    = 1'b0;
    cmd_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_jdo", 64'(jdo), 64'd0);
    check("rst_stb", 64'(w_obs), 64'd0);
    check("rst_pend", 64'(cmd_pending), 64'd0);
    check("rst_ovf", 64'(cmd_overflow), 64'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // latency: pending after E2, strobe after E3
    cmd_ready = 1'b1;
    ir_in     = 2'd0;
    sr        = mk(1'b0, 2'b01, 1'b0);
    vs_udr    = 1'b1;
    sb.push_back({ir_in, sr});
    repeat (3) @(posedge clk);
    #1;
    check("pend_e2", 64'(cmd_pending), 64'd1);
    check("oci_a_e2", 64'(take_action_ocimem_a), 64'd0);
    @(posedge clk);
    #1;
    check("oci_a_e3", 64'(take_action_ocimem_a), 64'd1);
    check("jdo_e3", 64'(jdo), 64'(sr));
    repeat (3) @(negedge clk);
    vs_udr = 1'b0;
    repeat (3) @(negedge clk);

    send(2'd2, mk(1'b1, 2'd2, 1'b0), 1'b1);
    send(2'd2, mk(1'b1, 2'd3, 1'b0), 1'b1);
    send(2'd2, mk(1'b0, 2'd1, 1'b0), 1'b1);
    send(2'd2, mk(1'b1, 2'd0, 1'b1), 1'b1);
    send(2'd0, mk(1'b0, 2'b10, 1'b0), 1'b1);
    send(2'd0, mk(1'b1, 2'b00, 1'b1), 1'b1);
    send(2'd3, mk(1'b0, 2'd0, 1'b1), 1'b1);
    send(2'd3, mk(1'b1, 2'd1, 1'b0), 1'b1);
    send(2'd1, mk(1'b1, 2'd0, 1'b1), 1'b1);
    repeat (4) @(negedge clk);
    check("drain1", 64'(sb.size()), 64'd0);

    // full queue: push and pop on the same edge
    cmd_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(2'd0, mk(1'b0, 2'(i), 1'b0), 1'b1);
    check("full_pend", 64'(cmd_pending), 64'd1);
    @(negedge clk);
    ir_in  = 2'd2;
    sr     = mk(1'b1, 2'd1, 1'b0);
    vs_udr = 1'b1;
    sb.push_back({ir_in, sr});
    @(negedge clk);
    @(negedge clk);
    cmd_ready = 1'b1;
    @(negedge clk);
    check("ovf_same_cycle", 64'(cmd_overflow), 64'd0);
    repeat (3) @(negedge clk);
    vs_udr = 1'b0;
    repeat (5) @(negedge clk);
    check("t4_pend", 64'(cmd_pending), 64'd0);
    check("t4_drain", 64'(sb.size()), 64'd0);

    // overflow, then clear with update-IR
    cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) check("ovf_before", 64'(cmd_overflow), 64'd0);
      send(2'd3, mk(1'b0, 2'd0, 1'(i)), sb.size() < 4);
    end
    check("ovf_pend", 64'(cmd_pending), 64'd1);
    check("ovf_set", 64'(cmd_overflow), 64'd1);
    @(negedge clk);
    vs_uir = 1'b1;
    repeat (5) @(negedge clk);
    check("ovf_clr", 64'(cmd_overflow), 64'd0);
    check("uir_keeps", 64'(cmd_pending), 64'd1);
    vs_uir = 1'b0;
    repeat (3) @(negedge clk);
    cmd_ready = 1'b1;
    repeat (8) @(negedge clk);
    check("t3_pend", 64'(cmd_pending), 64'd0);
    check("t3_drain", 64'(sb.size()), 64'd0);

    // reset mid-operation with update-DR held high
    cmd_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(2'd0, mk(1'b0, 2'b01, 1'b0), 1'b1);
    @(negedge clk);
    ir_in  = 2'd0;
    vs_udr = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    sb.delete();
    check("mid_rst_jdo", 64'(jdo), 64'd0);
    check("mid_rst_stb", 64'(w_obs), 64'd0);
    check("mid_rst_pend", 64'(cmd_pending), 64'd0);
    check("mid_rst_ovf", 64'(cmd_overflow), 64'd0);
    cmd_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("no_pulse_pend", 64'(cmd_pending), 64'd0);
    check("no_pulse_jdo", 64'(jdo), 64'd0);
    vs_udr = 1'b0;
    repeat (4) @(negedge clk);
    send(2'd3, mk(1'b0, 2'd2, 1'b1), 1'b1);
    repeat (6) @(negedge clk);
    check("final_drain", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
